// File: rtl/pulse_channel_seq.sv
// Square-wave channel core: period timer, duty/custom step sequencer, length counter, mute gating.
// Produces the gated 1-bit pulse consumed by the envelope/volume stage.
module pulse_channel_seq #(
    parameter int STEPS      = 8,
    parameter int TIMER_W    = 11,
    parameter int LEN_W      = 8,
    parameter int MIN_PERIOD = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      cpu_en,
    input  logic [TIMER_W-1:0]        period,
    input  logic [1:0]                duty,
    input  logic                      custom_en,
    input  logic [STEPS-1:0]          custom_pattern,
    input  logic                      phase_reset,
    input  logic                      length_load,
    input  logic [LEN_W-1:0]          length_value,
    input  logic                      length_halt,
    input  logic                      half_frame,
    input  logic                      channel_en,
    output logic                      pulse_out,
    output logic                      length_active,
    output logic [$clog2(STEPS)-1:0]  step_out
);

    localparam int STEP_W = $clog2(STEPS);
    localparam logic [STEP_W-1:0]  STEP_8TH  = STEP_W'(STEPS / 8);
    localparam logic [STEP_W-1:0]  STEP_QTR  = STEP_W'(STEPS / 4);
    localparam logic [STEP_W-1:0]  STEP_HALF = STEP_W'(STEPS / 2);
    localparam logic [TIMER_W-1:0] MIN_P     = TIMER_W'(MIN_PERIOD);

    logic [STEP_W-1:0]  step;
    logic [TIMER_W-1:0] timer;
    logic [LEN_W-1:0]   length;
    logic               raw;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            step   <= '0;
            timer  <= '0;
            length <= '0;
        end else if (cpu_en) begin
            if (timer == '0) begin
                timer <= period;
                step  <= step + 1'b1;
            end else begin
                timer <= timer - 1'b1;
            end
            // Later assignment wins: phase restart overrides a same-cycle advance.
            if (phase_reset)
                step <= '0;

            if (!channel_en)
                length <= '0;
            else if (length_load)
                length <= length_value;
            else if (half_frame && !length_halt && (length != '0))
                length <= length - 1'b1;
        end
    end

    always_comb begin
        raw = 1'b0;
        if (custom_en) begin
            raw = custom_pattern[step];
        end else begin
            case (duty)
                2'b00:   raw =  (step != '0) && (step <= STEP_8TH);
                2'b01:   raw =  (step != '0) && (step <= STEP_QTR);
                2'b10:   raw =  (step != '0) && (step <= STEP_HALF);
                default: raw = !((step != '0) && (step <= STEP_QTR));
            endcase
        end
    end

    assign length_active = (length != '0);
    assign pulse_out     = raw && length_active && (period >= MIN_P);
    assign step_out      = step;

endmodule

// File: tb/tb_pulse_channel_seq.sv
// Scoreboard bench for pulse_channel_seq: reference model pushes expected outputs per clock,
// an independent monitor pops and compares them against the DUT.
module tb_pulse_channel_seq;

    localparam int STEPS      = 8;
    localparam int TIMER_W    = 11;
    localparam int LEN_W      = 8;
    localparam int MIN_PERIOD = 8;
    localparam int STEP_W     = $clog2(STEPS);

    logic               clk = 1'b0;
    logic               reset_n;
    logic               cpu_en;
    logic [TIMER_W-1:0] period;
    logic [1:0]         duty;
    logic               custom_en;
    logic [STEPS-1:0]   custom_pattern;
    logic               phase_reset;
    logic               length_load;
    logic [LEN_W-1:0]   length_value;
    logic               length_halt;
    logic               half_frame;
    logic               channel_en;
    logic               pulse_out;
    logic               length_active;
    logic [STEP_W-1:0]  step_out;

    pulse_channel_seq #(
        .STEPS(STEPS), .TIMER_W(TIMER_W), .LEN_W(LEN_W), .MIN_PERIOD(MIN_PERIOD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cpu_en(cpu_en), .period(period), .duty(duty),
        .custom_en(custom_en), .custom_pattern(custom_pattern), .phase_reset(phase_reset),
        .length_load(length_load), .length_value(length_value), .length_halt(length_halt),
        .half_frame(half_frame), .channel_en(channel_en), .pulse_out(pulse_out),
        .length_active(length_active), .step_out(step_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit pulse;
        bit active;
        int step;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    // Reference model state: step index, countdown to next step, remaining length.
    int m_step = 0;
    int m_wait = 0;
    int m_len  = 0;

    function automatic bit duty_level(input int d, input int s);
        bit in_range;
        case (d)
            0: in_range = (s >= 1) && (s <= STEPS / 8);
            1: in_range = (s >= 1) && (s <= STEPS / 4);
            2: in_range = (s >= 1) && (s <= STEPS / 2);
            default: in_range = (s >= 1) && (s <= STEPS / 4);
        endcase
        return (d == 3) ? !in_range : in_range;
    endfunction

    task automatic model_edge();
        if (!reset_n) begin
            m_step = 0; m_wait = 0; m_len = 0;
        end else if (cpu_en) begin
            if (m_wait == 0) begin
                m_wait = int'(period);
                m_step = (m_step + 1) % STEPS;
            end else begin
                m_wait = m_wait - 1;
            end
            if (phase_reset) m_step = 0;
            if (!channel_en)                                 m_len = 0;
            else if (length_load)                            m_len = int'(length_value);
            else if (half_frame && !length_halt && m_len > 0) m_len = m_len - 1;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        bit   lvl;
        lvl      = custom_en ? custom_pattern[m_step] : duty_level(int'(duty), m_step);
        e.active = (m_len != 0);
        e.pulse  = lvl && e.active && (int'(period) >= MIN_PERIOD);
        e.step   = m_step;
        return e;
    endfunction

    // Inputs are changed at negedge; each posedge the model advances and queues expectations.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            exp_q.push_back(model_out());
            @(negedge clk);
            phase_reset = 1'b0;
            length_load = 1'b0;
            half_frame  = 1'b0;
        end
    endtask

    task automatic chk(input string name, input int act, input int req);
        total = total + 1;
        if (act == req) passed = passed + 1;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    endtask

    // Monitor: outputs are presented every clock, sampled 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pulse_out",     int'(pulse_out),     int'(e.pulse));
                chk("length_active", int'(length_active), int'(e.active));
                chk("step_out",      int'(step_out),      e.step);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; cpu_en = 1'b1; period = TIMER_W'(8); duty = 2'b00;
        custom_en = 1'b0; custom_pattern = '0; phase_reset = 1'b0;
        length_load = 1'b1; length_value = LEN_W'(10); length_halt = 1'b0;
        half_frame = 1'b0; channel_en = 1'b1;

        // Reset held with load requested: everything must stay cleared.
        for (int i = 0; i < 3; i++) begin
            length_load = 1'b1;
            run(1);
        end
        reset_n = 1'b1;
        run(1);

        // Period 8, duty 00, length 10: two full waves.
        length_load = 1'b1; length_value = LEN_W'(10);
        run(144);

        // Duty sweeps and custom pattern.
        duty = 2'b10; run(72);
        duty = 2'b11; run(72);
        custom_en = 1'b1; custom_pattern = 8'b1010_0101; run(72);
        custom_en = 1'b0; duty = 2'b01;

        // Boundary period: muted at 7, resumes at 8.
        period = TIMER_W'(7); run(64);
        period = TIMER_W'(8); run(72);

        // Length counter behaviour.
        length_load = 1'b1; length_value = LEN_W'(3); run(2);
        for (int i = 0; i < 3; i++) begin half_frame = 1'b1; run(2); end
        length_load = 1'b1; length_value = LEN_W'(5); half_frame = 1'b1; run(2);
        length_halt = 1'b1;
        for (int i = 0; i < 3; i++) begin half_frame = 1'b1; run(2); end
        length_halt = 1'b0;
        channel_en = 1'b0; run(3);
        channel_en = 1'b1; length_load = 1'b1; length_value = LEN_W'(200); run(1);

        // Enable gaps mid-period and phase reset on expiry.
        run(4);
        cpu_en = 1'b0; run(5);
        cpu_en = 1'b1; run(12);
        period = TIMER_W'(3);
        for (int i = 0; i < 6; i++) begin phase_reset = 1'b1; run(4); end
        period = TIMER_W'(8); run(20);

        // Randomised traffic.
        for (int i = 0; i < 2500; i++) begin
            cpu_en         = ($urandom_range(0, 9) != 0);
            period         = TIMER_W'($urandom_range(0, 14));
            duty           = 2'($urandom);
            custom_en      = ($urandom_range(0, 3) == 0);
            custom_pattern = STEPS'($urandom);
            phase_reset    = ($urandom_range(0, 30) == 0);
            length_load    = ($urandom_range(0, 40) == 0);
            length_value   = LEN_W'($urandom_range(0, 12));
            length_halt    = ($urandom_range(0, 4) == 0);
            half_frame     = ($urandom_range(0, 6) == 0);
            channel_en     = ($urandom_range(0, 60) != 0);
            reset_n        = ($urandom_range(0, 400) != 0);
            run(1);
        end

        @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            total = total + 1;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
